// File: rtl/mak8_mode_pkg.sv
// Shared types for the moded program ROM and its sequencer: program
// modes, sequencer states and the raw-switch normalisation helper.
package mak8_mode_pkg;

  typedef enum logic [2:0] {
    MODE_FREE    = 3'b000,
    MODE_COUNTER = 3'b001,
    MODE_TEMP    = 3'b010
  } mode_t;

  typedef enum logic [2:0] {
    SEQ_RUN      = 3'd0,
    SEQ_FILTER   = 3'd1,
    SEQ_HOLD_REQ = 3'd2,
    SEQ_DRAIN    = 3'd3,
    SEQ_SWITCH   = 3'd4,
    SEQ_RESTART  = 3'd5,
    SEQ_RELEASE  = 3'd6
  } seq_state_t;

  // Map a raw switch code onto a legal program; unknown codes fall back to FREE.
  function automatic mode_t norm_mode(input logic [2:0] raw);
    mode_t m;
    case (raw)
      3'b001:  m = MODE_COUNTER;
      3'b010:  m = MODE_TEMP;
      default: m = MODE_FREE;
    endcase
    return m;
  endfunction

  // Largest of three counter limits, used to size the shared counters.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/program_mode_sequencer_if.sv
// Signal bundle between the mode sequencer and its neighbours (switch block,
// CPU fetch stage, program ROM). The sequencer uses the master view.
interface program_mode_sequencer_if #(
  parameter int MODE_W = 3
);
  logic [MODE_W-1:0] mode_req;
  logic              hold_ack;
  logic              cpu_halted;
  logic [MODE_W-1:0] rom_mode;
  logic              cpu_hold;
  logic              cpu_pc_reset;
  logic              busy;
  logic              mode_changed;
  logic              ack_timeout;

  modport master (
    input  mode_req, hold_ack, cpu_halted,
    output rom_mode, cpu_hold, cpu_pc_reset, busy, mode_changed, ack_timeout
  );

  modport slave (
    output mode_req, hold_ack, cpu_halted,
    input  rom_mode, cpu_hold, cpu_pc_reset, busy, mode_changed, ack_timeout
  );
endinterface

// File: rtl/program_mode_sequencer_filter.sv
// Debounce for the raw mode request: normalises the switch code, remembers
// the candidate mode and reports when it has been stable long enough.
import mak8_mode_pkg::*;

module mode_req_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode_req,
  input  mode_t      rom_mode,
  input  logic       arm,      // sequencer idle: start a new candidate
  input  logic       active,   // sequencer filtering: keep counting
  output mode_t      pend,
  output logic       differs,
  output logic       hit
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  mode_t            req_norm_s;
  mode_t            pend_r;
  logic [CNT_W-1:0] cnt_r;
  logic             same_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) r = v;
    else              r = v + CNT_W'(1);
    return r;
  endfunction

  // Compare the normalised request against the live mode and the candidate.
  always_comb begin
    req_norm_s = norm_mode(mode_req);
    differs    = (req_norm_s != rom_mode);
    same_s     = (req_norm_s == pend_r);
    hit        = active && differs && same_s && (cnt_r >= STABLE_LAST);
  end

  // Track the candidate mode and how many consecutive samples agreed with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= MODE_FREE;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (arm || active) begin
      if (!differs) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (arm || !same_s) begin
        pend_r <= req_norm_s;
        cnt_r  <= CNT_W'(1);
      end else begin
        cnt_r <= sat_inc(cnt_r);
      end
    end else begin
      pend_r <= pend_r;   // frozen while a switch is in progress
      cnt_r  <= cnt_r;
    end
  end

  assign pend = pend_r;

endmodule

// File: rtl/program_mode_sequencer.sv
// Program-select sequencer: stalls the CPU, drains the ROM's registered
// read, commits the new program mode, pulses a PC reset and releases the CPU.
import mak8_mode_pkg::*;

module program_mode_sequencer #(
  parameter int MODE_W        = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int DRAIN_CYCLES  = 2,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  program_mode_sequencer_if.master  bus
);

  localparam int CNT_W = $clog2(max3(STABLE_CYCLES, DRAIN_CYCLES, ACK_TIMEOUT) + 1);

  localparam logic [2:0] ST_RUN      = SEQ_RUN;
  localparam logic [2:0] ST_FILTER   = SEQ_FILTER;
  localparam logic [2:0] ST_HOLD_REQ = SEQ_HOLD_REQ;
  localparam logic [2:0] ST_DRAIN    = SEQ_DRAIN;
  localparam logic [2:0] ST_SWITCH   = SEQ_SWITCH;
  localparam logic [2:0] ST_RESTART  = SEQ_RESTART;
  localparam logic [2:0] ST_RELEASE  = SEQ_RELEASE;

  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [2:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] tcnt_r, tcnt_nxt_s;
  logic             timeout_set_s;
  logic             ack_s;
  logic             hold_nxt_s;

  mode_t            pend_s;
  logic             differs_s;
  logic             hit_s;

  mode_t            rom_mode_r;
  logic             cpu_hold_r;
  logic             cpu_pc_reset_r;
  logic             busy_r;
  logic             mode_changed_r;
  logic             ack_timeout_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) r = v;
    else              r = v + CNT_W'(1);
    return r;
  endfunction

  mode_req_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .mode_req (bus.mode_req[2:0]),
    .rom_mode (rom_mode_r),
    .arm      (state_r == ST_RUN),
    .active   (state_r == ST_FILTER),
    .pend     (pend_s),
    .differs  (differs_s),
    .hit      (hit_s)
  );

  // A halted CPU cannot fetch, so HLT is as good as an explicit ack.
  assign ack_s = bus.hold_ack | bus.cpu_halted;

  // Next-state and in-state counter for the switch sequence.
  always_comb begin
    state_nxt_s   = state_r;
    tcnt_nxt_s    = tcnt_r;
    timeout_set_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (differs_s) state_nxt_s = ST_FILTER;
        else           state_nxt_s = ST_RUN;
      end
      ST_FILTER: begin
        if (!differs_s) begin
          state_nxt_s = ST_RUN;
        end else if (hit_s) begin
          state_nxt_s = ST_HOLD_REQ;
          tcnt_nxt_s  = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_FILTER;
        end
      end
      ST_HOLD_REQ: begin
        // an ack on the timeout edge still wins, so no timeout is flagged
        if (ack_s) begin
          state_nxt_s = ST_DRAIN;
          tcnt_nxt_s  = {CNT_W{1'b0}};
        end else if (tcnt_r >= TO_LAST) begin
          state_nxt_s   = ST_DRAIN;
          tcnt_nxt_s    = {CNT_W{1'b0}};
          timeout_set_s = 1'b1;
        end else begin
          tcnt_nxt_s = sat_inc(tcnt_r);
        end
      end
      ST_DRAIN: begin
        if (tcnt_r >= DRAIN_LAST) begin
          state_nxt_s = ST_SWITCH;
          tcnt_nxt_s  = {CNT_W{1'b0}};
        end else begin
          tcnt_nxt_s = sat_inc(tcnt_r);
        end
      end
      ST_SWITCH:  state_nxt_s = ST_RESTART;
      ST_RESTART: state_nxt_s = ST_RELEASE;
      ST_RELEASE: state_nxt_s = ST_RUN;
      default: begin
        state_nxt_s = ST_RUN;
        tcnt_nxt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // cpu_hold covers HOLD_REQ through RELEASE of the upcoming cycle.
  always_comb begin
    case (state_nxt_s)
      ST_HOLD_REQ, ST_DRAIN, ST_SWITCH, ST_RESTART, ST_RELEASE: hold_nxt_s = 1'b1;
      default:                                                  hold_nxt_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs; reset abandons any switch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_RUN;
      tcnt_r         <= {CNT_W{1'b0}};
      rom_mode_r     <= MODE_FREE;
      cpu_hold_r     <= 1'b0;
      cpu_pc_reset_r <= 1'b0;
      busy_r         <= 1'b0;
      mode_changed_r <= 1'b0;
      ack_timeout_r  <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      tcnt_r         <= tcnt_nxt_s;
      if (state_r == ST_SWITCH) rom_mode_r <= pend_s;
      else                      rom_mode_r <= rom_mode_r;
      cpu_hold_r     <= hold_nxt_s;
      cpu_pc_reset_r <= (state_nxt_s == ST_RESTART);
      busy_r         <= (state_nxt_s != ST_RUN);
      mode_changed_r <= (state_r == ST_RELEASE);
      ack_timeout_r  <= ack_timeout_r | timeout_set_s;
    end
  end

  assign bus.rom_mode     = MODE_W'(rom_mode_r);
  assign bus.cpu_hold     = cpu_hold_r;
  assign bus.cpu_pc_reset = cpu_pc_reset_r;
  assign bus.busy         = busy_r;
  assign bus.mode_changed = mode_changed_r;
  assign bus.ack_timeout  = ack_timeout_r;

endmodule

// File: tb/tb_program_mode_sequencer.sv
// Self-checking bench for program_mode_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a schedule-based model.
module tb_program_mode_sequencer;

  localparam int S  = 4;
  localparam int D  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  program_mode_sequencer_if #(.MODE_W(3)) bus_if ();

  program_mode_sequencer #(
    .MODE_W        (3),
    .STABLE_CYCLES (S),
    .DRAIN_CYCLES  (D),
    .ACK_TIMEOUT   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt = total_cnt + 1;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else            pass_cnt = pass_cnt + 1;
  endtask

  function automatic logic [2:0] tb_norm(input logic [2:0] r);
    if (r == 3'd1)      return 3'd1;
    else if (r == 3'd2) return 3'd2;
    else                return 3'd0;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       hold;
    logic       pc;
    logic       busy;
    logic       chg;
    logic [2:0] rom;
  } exp_t;

  exp_t       tail_q[$];
  exp_t       cur;
  logic [2:0] m_rom;
  logic [2:0] smode;
  int         streak;
  bit         waiting;
  int         elapsed;
  logic       m_to;
  bit         model_valid = 1'b0;
  int         need;

  // One model step per clock edge: the expected outputs after this edge.
  always @(posedge clk) begin
    logic [2:0] n;
    need = (S < 2) ? 2 : S;
    if (rst) begin
      tail_q.delete();
      m_rom = 3'd0; smode = 3'd0; streak = 0; waiting = 0; elapsed = 0; m_to = 1'b0;
      cur = '{hold: 1'b0, pc: 1'b0, busy: 1'b0, chg: 1'b0, rom: 3'd0};
    end else if (tail_q.size() > 0) begin
      cur = tail_q.pop_front();
    end else if (waiting) begin
      elapsed = elapsed + 1;
      if (bus_if.hold_ack || bus_if.cpu_halted || elapsed >= TO) begin
        if (!(bus_if.hold_ack || bus_if.cpu_halted)) m_to = 1'b1;
        waiting = 0;
        for (int k = 0; k < D + 1; k++) tail_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, m_rom});
        tail_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, smode});
        tail_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, smode});
        tail_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, smode});
        cur = tail_q.pop_front();
      end else begin
        cur = '{1'b1, 1'b0, 1'b1, 1'b0, m_rom};
      end
    end else begin
      n = tb_norm(bus_if.mode_req);
      if (n == m_rom) streak = 0;
      else if (streak > 0 && n == smode) streak = streak + 1;
      else begin smode = n; streak = 1; end
      if (streak >= need) begin
        waiting = 1; elapsed = 0; streak = 0;
        cur = '{1'b1, 1'b0, 1'b1, 1'b0, m_rom};
      end else begin
        cur = '{1'b0, 1'b0, (streak > 0), 1'b0, m_rom};
      end
    end
    m_rom = cur.rom;
    model_valid = 1'b1;
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("rom_mode",     bus_if.rom_mode,     cur.rom);
      chk("cpu_hold",     bus_if.cpu_hold,     cur.hold);
      chk("cpu_pc_reset", bus_if.cpu_pc_reset, cur.pc);
      chk("busy",         bus_if.busy,         cur.busy);
      chk("mode_changed", bus_if.mode_changed, cur.chg);
      chk("ack_timeout",  bus_if.ack_timeout,  m_to);
    end
  end

  // ---------------- hold-window monitor for directed checks ----------------
  int run_len = 0, pc_pos = 0, pc_cnt = 0;
  int last_len = 0, last_pc_pos = 0, last_pc_cnt = 0, rom_at_pc = 0, chg_at_drop = 0;
  int hold_runs = 0, chg_cnt = 0, last_chg_rom = 0, prev_chg_rom = 0;

  // Measure each cpu_hold window and record commits seen on mode_changed.
  always @(negedge clk) begin
    if (bus_if.mode_changed) begin
      chg_cnt = chg_cnt + 1;
      prev_chg_rom = last_chg_rom;
      last_chg_rom = bus_if.rom_mode;
    end
    if (bus_if.cpu_hold === 1'b1) begin
      run_len = run_len + 1;
      if (bus_if.cpu_pc_reset) begin
        pc_pos = run_len; pc_cnt = pc_cnt + 1; rom_at_pc = bus_if.rom_mode;
      end
    end else if (run_len > 0) begin
      last_len = run_len; last_pc_pos = pc_pos; last_pc_cnt = pc_cnt;
      chg_at_drop = bus_if.mode_changed;
      hold_runs = hold_runs + 1;
      run_len = 0; pc_pos = 0; pc_cnt = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int runs0, chg0;

  initial begin
    rst = 1'b1;
    bus_if.mode_req   = 3'b001;
    bus_if.hold_ack   = 1'b1;
    bus_if.cpu_halted = 1'b0;

    // 1. reset with a pending request, then the switch proceeds
    cycles(3);
    chk("rst_rom_mode", bus_if.rom_mode, 0);
    chk("rst_cpu_hold", bus_if.cpu_hold, 0);
    chk("rst_busy",     bus_if.busy,     0);
    rst = 1'b0;
    runs0 = hold_runs;
    cycles(20);
    chk("t1_hold_runs",  hold_runs - runs0, 1);
    chk("t1_hold_len",   last_len,    6);
    chk("t1_pc_pos",     last_pc_pos, 5);
    chk("t1_pc_cnt",     last_pc_cnt, 1);
    chk("t1_rom_at_pc",  rom_at_pc,   1);
    chk("t1_chg_at_drop", chg_at_drop, 1);
    chk("t1_rom_mode",   bus_if.rom_mode, 1);

    // 2. basic switch back to FREE
    bus_if.mode_req = 3'b000;
    cycles(20);
    chk("t2_hold_len", last_len, 6);
    chk("t2_rom_mode", bus_if.rom_mode, 0);

    // 3. glitch filtering
    runs0 = hold_runs;
    bus_if.mode_req = 3'b010;
    cycles(3);
    bus_if.mode_req = 3'b000;
    cycles(10);
    chk("t3_glitch_runs", hold_runs - runs0, 0);
    chk("t3_glitch_rom",  bus_if.rom_mode, 0);
    bus_if.mode_req = 3'b111;
    cycles(10);
    chk("t3_illegal_runs", hold_runs - runs0, 0);
    chk("t3_illegal_busy", bus_if.busy, 0);
    bus_if.mode_req = 3'b001;
    cycles(2);
    bus_if.mode_req = 3'b010;
    cycles(20);
    chk("t3_relatch_runs", hold_runs - runs0, 1);
    chk("t3_relatch_rom",  bus_if.rom_mode, 2);

    // 4. ack timeout, then an HLT-acknowledged switch
    bus_if.hold_ack = 1'b0;
    bus_if.mode_req = 3'b001;
    cycles(40);
    chk("t4_to_hold_len", last_len, 21);
    chk("t4_ack_timeout", bus_if.ack_timeout, 1);
    chk("t4_to_rom",      bus_if.rom_mode, 1);
    bus_if.cpu_halted = 1'b1;
    bus_if.mode_req   = 3'b010;
    cycles(20);
    chk("t4_hlt_hold_len", last_len, 6);
    chk("t4_sticky",       bus_if.ack_timeout, 1);
    chk("t4_hlt_rom",      bus_if.rom_mode, 2);

    // 5. request changes while draining: commit first, then switch again
    bus_if.cpu_halted = 1'b0;
    bus_if.hold_ack   = 1'b1;
    runs0 = hold_runs; chg0 = chg_cnt;
    bus_if.mode_req = 3'b000;
    cycles(5);
    bus_if.mode_req = 3'b010;
    cycles(40);
    chk("t5_runs",       hold_runs - runs0, 2);
    chk("t5_chg_pulses", chg_cnt - chg0, 2);
    chk("t5_first_rom",  prev_chg_rom, 0);
    chk("t5_second_rom", last_chg_rom, 2);

    // 6. reset in DRAIN aborts the switch
    chg0 = chg_cnt;
    bus_if.mode_req = 3'b001;
    cycles(5);
    chk("t6_in_drain_hold", bus_if.cpu_hold, 1);
    rst = 1'b1;
    cycles(1);
    chk("t6_hold", bus_if.cpu_hold, 0);
    chk("t6_rom",  bus_if.rom_mode, 0);
    chk("t6_to",   bus_if.ack_timeout, 0);
    rst = 1'b0;
    bus_if.mode_req = 3'b000;
    cycles(10);
    chk("t6_pc_cnt", last_pc_cnt, 0);
    chk("t6_no_chg", chg_cnt - chg0, 0);

    // random traffic, mostly prompt acks
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bus_if.mode_req = 3'($urandom_range(0, 7));
      bus_if.hold_ack   = ($urandom_range(0, 3) == 0);
      bus_if.cpu_halted = ($urandom_range(0, 15) == 0);
      rst               = ($urandom_range(0, 499) == 0);
    end
    // random traffic with slow acks to exercise timeouts
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) bus_if.mode_req = 3'($urandom_range(0, 3));
      bus_if.hold_ack   = ($urandom_range(0, 19) == 0);
      bus_if.cpu_halted = 1'b0;
      rst               = ($urandom_range(0, 999) == 0);
    end
    rst = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
